dmem_responder: RTL and testbench

Memory-side responder for the core's MEM-stage data port. It answers the pipeline's address/write-data/write-enable requests with same-cycle read data.
- Decodes a word-addressed data RAM plus a small MMIO register window: 64-bit cycle counter, LED register, store counter.
- Sits outside the datapath and connects to its ALUResult/WriteData/MemWrite/ReadData port.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_mmio_regs.sv | 110 +++++++++++
 rtl/dmem_responder.sv | 86 ++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
// Contents: MMIO word offsets, LED register width, region-select enumeration.
package dmem_pkg;

    localparam logic [4:0] OFF_CYCLE_LO   = 5'h00;
    localparam logic [4:0] OFF_CYCLE_HI   = 5'h04;
    localparam logic [4:0] OFF_LED        = 5'h08;
    localparam logic [4:0] OFF_STORE_CNT  = 5'h0C;
    localparam logic [4:0] OFF_FAULT_ADDR = 5'h10;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

endpackage

// File: rtl/dmem_mmio_regs.sv
// rtl/dmem_mmio_regs.sv - MMIO register block: cycle counter, hi snapshot, LED, store counter, fault
// Build option: DMEM_FAULT_EN adds the sticky fault flag and FAULT_ADDR register.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   sel            : current address falls in the MMIO window
//   mem_write      : store request this cycle
//   store_fault    : current store is a faulting access (always 0 without DMEM_FAULT_EN)
//   ram_store      : a RAM store is committed at this edge
//   addr, wdata    : byte address and store data from the core
//   rdata          : combinational register read data for the addressed offset
//   leds, fault    : LED register and sticky fault flag
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             mem_write,
    input  logic             store_fault,
    input  logic             ram_store,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] leds,
    output logic             fault
);

    logic [4:0]       offset;
    logic             wr;
    logic [63:0]      cycle_q, cycle_d;
    logic [31:0]      hi_snap_q, hi_snap_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      store_cnt_q, store_cnt_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    // Byte-lane bits are ignored for decode.
    assign offset = {addr[4:2], 2'b00};
    assign wr     = sel && mem_write && !store_fault;

    always_comb begin
        cycle_d      = cycle_q + 64'd1;
        hi_snap_d    = hi_snap_q;
        led_d        = led_q;
        store_cnt_d  = store_cnt_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        // A load of CYCLE_LO freezes the upper half so the following
        // CYCLE_HI load is coherent with it.
        if (sel && !mem_write && offset == OFF_CYCLE_LO) begin
            hi_snap_d = cycle_q[63:32];
        end
        if (wr && offset == OFF_LED) begin
            led_d = wdata[LED_W-1:0];
        end
        if (ram_store) begin
            store_cnt_d = store_cnt_q + 32'd1;
        end
`ifdef DMEM_FAULT_EN
        if (wr && offset == OFF_FAULT_ADDR) begin
            fault_d      = 1'b0;
            fault_addr_d = 32'd0;
        end else if (store_fault && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = addr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q      <= 64'd0;
            hi_snap_q    <= 32'd0;
            led_q        <= '0;
            store_cnt_q  <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            cycle_q      <= cycle_d;
            hi_snap_q    <= hi_snap_d;
            led_q        <= led_d;
            store_cnt_q  <= store_cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (offset)
            OFF_CYCLE_LO:   rdata = cycle_q[31:0];
            OFF_CYCLE_HI:   rdata = hi_snap_q;
            OFF_LED:        rdata = {{(32-LED_W){1'b0}}, led_q};
            OFF_STORE_CNT:  rdata = store_cnt_q;
`ifdef DMEM_FAULT_EN
            OFF_FAULT_ADDR: rdata = fault_addr_q;
`endif
            default:        rdata = 32'd0;
        endcase
    end

    assign leds  = led_q;
    assign fault = fault_q;

    logic unused_bits;
    assign unused_bits = ^{addr[31:5], addr[1:0], wdata[31:LED_W], store_fault,
                           fault_addr_q};

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data responder: word RAM plus MMIO window, same-cycle reads
// Build option: DMEM_FAULT_EN enables misaligned/unmapped store faulting.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (RAM contents are not reset)
//   MemWrite     : store request this cycle
//   Addr         : byte address from the core
//   WriteData    : store data
//   ReadData     : combinational load data for Addr
//   leds         : LED register
//   fault        : sticky store fault flag (0 without DMEM_FAULT_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] leds,
    output logic             fault
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   ram_q [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    region_e       region;
    logic          store_fault;
    logic          ram_we;
    logic [31:0]   mmio_rdata;

    always_comb begin
        region = REGION_NONE;
        if (Addr < RAM_BYTES) begin
            region = REGION_RAM;
        end else if (Addr[31:5] == MMIO_BASE[31:5]) begin
            region = REGION_MMIO;
        end
    end

    assign ram_idx = Addr[AW+1:2];

`ifdef DMEM_FAULT_EN
    assign store_fault = MemWrite && ((Addr[1:0] != 2'b00) || (region == REGION_NONE));
`else
    assign store_fault = 1'b0;
`endif

    // Reset wins over a coincident store, including the RAM write.
    assign ram_we = MemWrite && !reset && !store_fault && (region == REGION_RAM);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    dmem_mmio_regs u_regs (
        .clk         (clk),
        .reset       (reset),
        .sel         (region == REGION_MMIO),
        .mem_write   (MemWrite),
        .store_fault (store_fault),
        .ram_store   (ram_we),
        .addr        (Addr),
        .wdata       (WriteData),
        .rdata       (mmio_rdata),
        .leds        (leds),
        .fault       (fault)
    );

    always_comb begin
        ReadData = 32'd0;
        case (region)
            REGION_RAM:  ReadData = ram_q[ram_idx];
            REGION_MMIO: ReadData = mmio_rdata;
            default:     ReadData = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a behavioural reference model
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] MB    = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        fault;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .leds      (leds),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ram_m [DEPTH];
    bit          ram_v [DEPTH];
    logic [63:0] cyc_m;
    logic [31:0] snap_m, cnt_m, faddr_m;
    logic [7:0]  led_m;
    bit          fault_m;
    bit          model_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >> 5) == (MB >> 5);
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
`ifdef DMEM_FAULT_EN
        return (a % 4 != 0) || !(in_ram(a) || in_mmio(a));
`else
        return (a == 32'hFFFF_FFFF) && (a == 32'd0);
`endif
    endfunction

    // Returns 0 when the expected value is unknown (unwritten RAM word).
    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int off;
        v = 32'd0;
        if (in_ram(a)) begin
            if (!ram_v[a / 4]) return 0;
            v = ram_m[a / 4];
            return 1;
        end
        if (in_mmio(a)) begin
            off = int'(a & 32'h1C);
            case (off)
                'h00: v = cyc_m[31:0];
                'h04: v = snap_m;
                'h08: v = {24'd0, led_m};
                'h0C: v = cnt_m;
`ifdef DMEM_FAULT_EN
                'h10: v = faddr_m;
`endif
                default: v = 32'd0;
            endcase
        end
        return 1;
    endfunction

    task automatic model_update(input bit rst, input bit we, input logic [31:0] a,
                                input logic [31:0] wd);
        int off;
        off = int'(a & 32'h1C);
        if (rst) begin
            cyc_m = 64'd0; snap_m = 32'd0; led_m = 8'd0; cnt_m = 32'd0;
            fault_m = 0; faddr_m = 32'd0;
            return;
        end
        if (we) begin
            if (is_fault(a)) begin
                if (!fault_m) begin
                    fault_m = 1;
                    faddr_m = a;
                end
            end else if (in_ram(a)) begin
                ram_m[a / 4] = wd;
                ram_v[a / 4] = 1;
                cnt_m = cnt_m + 32'd1;
            end else if (in_mmio(a)) begin
                if (off == 'h08) led_m = wd[7:0];
`ifdef DMEM_FAULT_EN
                if (off == 'h10) begin
                    fault_m = 0;
                    faddr_m = 32'd0;
                end
`endif
            end
        end else if (in_mmio(a) && off == 'h00) begin
            snap_m = cyc_m[63:32];
        end
        cyc_m = cyc_m + 64'd1;
    endtask

    task automatic step(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] ev;
        @(negedge clk);
        reset = rst; MemWrite = we; Addr = a; WriteData = wd;
        #1;
        rd = ReadData;
        if (model_valid) begin
            if (model_read(a, ev)) chk($sformatf("read@%h", a), rd, ev);
            chk("leds", {24'd0, leds}, {24'd0, led_m});
            chk("fault", {31'd0, fault}, {31'd0, fault_m});
        end
        @(posedge clk);
        model_update(rst, we, a, wd);
        if (rst) model_valid = 1;
    endtask

    logic [31:0] rd;
    logic [31:0] a;
    bit          we;
    int          kind;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_v[i] = 0;

        // Reset, with a coincident store that must be suppressed
        step(1, 0, 32'h0, 32'h0, rd);
        step(1, 1, 32'h20, 32'h1234_5678, rd);
        step(0, 0, MB + 32'h00, 32'h0, rd);
        chk("cycle_first", rd, 32'h0);
        step(0, 0, MB + 32'h0C, 32'h0, rd);
        chk("store_cnt_reset", rd, 32'h0);
        chk("leds_reset", {24'd0, leds}, 32'h0);

        // RAM store then next-cycle load
        step(0, 1, 32'h10, 32'hDEAD_BEEF, rd);
        step(0, 0, 32'h10, 32'h0, rd);
        chk("ram_10", rd, 32'hDEAD_BEEF);
        step(0, 0, MB + 32'h0C, 32'h0, rd);
        chk("store_cnt_1", rd, 32'h1);

        // Read-during-write returns old data
        step(0, 1, 32'h14, 32'h1, rd);
        step(0, 1, 32'h14, 32'h2, rd);
        chk("rdw_old", rd, 32'h1);
        step(0, 0, 32'h14, 32'h0, rd);
        chk("rdw_new", rd, 32'h2);

        // LED register
        step(0, 1, MB + 32'h08, 32'h1A5, rd);
        step(0, 0, MB + 32'h08, 32'h0, rd);
        chk("led_read", rd, 32'h0000_00A5);
        chk("leds_pin", {24'd0, leds}, 32'hA5);
        step(0, 0, MB + 32'h0C, 32'h0, rd);
        chk("store_cnt_3", rd, 32'h3);

        // Mid-run reset with a RAM store: registers clear, RAM kept, store dropped
        step(1, 1, 32'h10, 32'h5555_5555, rd);
        step(0, 0, 32'h10, 32'h0, rd);
        chk("ram_kept", rd, 32'hDEAD_BEEF);
        chk("leds_after_reset", {24'd0, leds}, 32'h0);

        // Stores to read-only, unmapped and reserved locations
        step(0, 1, MB + 32'h00, 32'hFFFF_0000, rd);
        step(0, 1, 32'h2000, 32'h7777_7777, rd);
        step(0, 1, MB + 32'h1C, 32'h6666_6666, rd);
        step(0, 0, 32'h2000, 32'h0, rd);
        chk("unmapped_rd", rd, 32'h0);
        step(0, 0, MB + 32'h1C, 32'h0, rd);
        chk("reserved_rd", rd, 32'h0);
        step(0, 0, MB + 32'h0C, 32'h0, rd);
        chk("store_cnt_ro", rd, 32'h0);
        step(0, 0, 32'h100, 32'h0, rd);
        chk("ram_end_boundary", rd, 32'h0);

        // Fault behaviour (or its absence)
        step(0, 1, 32'h4, 32'h0000_0044, rd);
`ifdef DMEM_FAULT_EN
        step(0, 1, 32'h6, 32'h0000_0BAD, rd);
        step(0, 0, MB + 32'h10, 32'h0, rd);
        chk("fault_addr", rd, 32'h6);
        chk("fault_set", {31'd0, fault}, 32'h1);
        step(0, 0, 32'h4, 32'h0, rd);
        chk("fault_word_kept", rd, 32'h44);
        step(0, 1, 32'h3000, 32'h1, rd);
        step(0, 0, MB + 32'h10, 32'h0, rd);
        chk("fault_addr_sticky", rd, 32'h6);
        step(0, 1, MB + 32'h10, 32'h0, rd);
        step(0, 0, MB + 32'h10, 32'h0, rd);
        chk("fault_clear", {31'd0, fault}, 32'h0);
        chk("fault_addr_clear", rd, 32'h0);
`else
        step(0, 1, 32'h6, 32'h0000_0066, rd);
        step(0, 0, 32'h4, 32'h0, rd);
        chk("misaligned_store", rd, 32'h66);
        chk("fault_tied", {31'd0, fault}, 32'h0);
        step(0, 0, MB + 32'h10, 32'h0, rd);
        chk("off10_unmapped", rd, 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            we = ($urandom_range(0, 2) == 0);
            if (kind <= 4) begin
                if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 7)) * 4;
                else a = 32'($urandom_range(56, 63)) * 4;
            end else if (kind <= 7) begin
                a = MB + 32'($urandom_range(0, 7)) * 4;
            end else if (kind == 8) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h2000;
                    1: a = 32'h3000;
                    2: a = 32'h100;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end else begin
                a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) * 4
                                                : MB + 32'($urandom_range(0, 7)) * 4;
                a = a + 32'($urandom_range(1, 3));
            end
            step(($urandom_range(0, 99) == 0), we, a, $urandom, rd);
        end

        // Cycle counter wrap with a coherent hi snapshot
        @(negedge clk);
        reset = 0; MemWrite = 0; Addr = MB + 32'h00; WriteData = 32'd0;
        force dut.u_regs.cycle_q = 64'hFFFF_FFFF_FFFF_FFF0;
        #1;
        chk("cycle_lo_forced", ReadData, 32'hFFFF_FFF0);
        @(posedge clk);
        #1;
        release dut.u_regs.cycle_q;
        @(negedge clk);
        Addr = MB + 32'h04;
        repeat (20) @(negedge clk);
        #1;
        chk("cycle_hi_snap", ReadData, 32'hFFFF_FFFF);
        Addr = MB + 32'h00;
        #1;
        checks++;
        assert (ReadData < 32'h20) else begin
            errors++;
            $error("FAIL cycle_wrap: observed %h expected below 00000020", ReadData);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
